// File: rtl/mem_stage_lsu.sv
// Memory stage: aligns loads/stores onto a ready/valid data port and returns one registered result per instruction.
// ALU ops take 1 cycle; stores take at least 2 and loads at least 3. stall_o holds upstream while a transaction is outstanding.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_rs2_data,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  output logic        stall_o,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_wb_data,
  output logic        out_exc
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      state, state_nxt;
  logic [31:0] pc_q, addr_q, wdata_q, cnt_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  wstrb_q;

  logic        mem_op, f3_ok, misal, req_exc;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  always_comb begin
    mem_op = in_load | in_store;
    if (in_store) begin
      f3_ok = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end else begin
      f3_ok = !((in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111));
    end
    case (in_funct3[1:0])
      2'b01:   misal = in_alu_out[0];
      2'b10:   misal = |in_alu_out[1:0];
      default: misal = 1'b0;
    endcase
    req_exc = (in_load & in_store) | !f3_ok | misal;

    case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << in_alu_out[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_rs2_data[15:0]}};
        st_wstrb = in_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = in_rs2_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load lane extraction works on the captured address, not the live inputs.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = dm_rdata[7:0];
      2'b01:   ld_byte = dm_rdata[15:8];
      2'b10:   ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (f3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_result = dm_rdata;
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = 32'd0;
    endcase
  end

  logic        timeout_hit;
  logic        fin, fin_exc, capture;
  logic [31:0] fin_pc, fin_data;

  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fin       = 1'b0;
    fin_exc   = 1'b0;
    fin_pc    = pc_q;
    fin_data  = 32'd0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            fin      = 1'b1;
            fin_pc   = in_pc;
            fin_data = in_alu_out;
          end else if (req_exc) begin
            fin     = 1'b1;
            fin_exc = 1'b1;
            fin_pc  = in_pc;
          end else begin
            capture   = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        // Read data arriving alongside the accept is deliberately ignored.
        if (dm_ready) begin
          if (we_q) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end else if (timeout_hit) begin
          fin       = 1'b1;
          fin_exc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      RESP: begin
        if (dm_rvalid) begin
          fin       = 1'b1;
          fin_data  = ld_result;
          state_nxt = IDLE;
        end else if (timeout_hit) begin
          fin       = 1'b1;
          fin_exc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'd0;
      out_wb_data <= 32'd0;
      out_exc     <= 1'b0;
      pc_q        <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      f3_q        <= 3'd0;
      we_q        <= 1'b0;
      cnt_q       <= 32'd0;
    end else begin
      out_valid <= fin;
      if (fin) begin
        out_pc      <= fin_pc;
        out_wb_data <= fin_data;
        out_exc     <= fin_exc;
      end
      if (capture) begin
        pc_q    <= in_pc;
        addr_q  <= in_alu_out;
        f3_q    <= in_funct3;
        we_q    <= in_store;
        wdata_q <= st_wdata;
        wstrb_q <= in_store ? st_wstrb : 4'd0;
        cnt_q   <= 32'd0;
      end else if (state != IDLE) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign stall_o  = (state != IDLE);
  assign dm_req   = (state == REQ);
  assign dm_we    = we_q & (state == REQ);
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wdata = wdata_q;
  assign dm_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu; results are matched against a queue of expected completions.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_load, in_store;
  logic [31:0] in_pc, in_alu_out, in_rs2_data;
  logic [2:0]  in_funct3;
  logic        stall_o, dm_req, dm_we, dm_ready, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb;
  logic        out_valid, out_exc;
  logic [31:0] out_pc, out_wb_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_out(in_alu_out),
    .in_rs2_data(in_rs2_data), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .stall_o(stall_o),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .out_valid(out_valid), .out_pc(out_pc),
    .out_wb_data(out_wb_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_out_valid: observed pc %h expected no result", out_pc);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("out_wb_data", out_wb_data, mon_e.data);
        check("out_exc", {31'd0, out_exc}, {31'd0, mon_e.exc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic ld, input logic st, input logic [2:0] f3);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_alu_out  = addr;
    in_rs2_data = rs2;
    in_load     = ld;
    in_store    = st;
    in_funct3   = f3;
  endtask

  task automatic do_alu(input logic [31:0] pc, input logic [31:0] val);
    issue(pc, val, 32'h0, 1'b0, 1'b0, 3'b000);
    sb.push_back('{pc: pc, data: val, exc: 1'b0});
    check("alu_stall_before", {31'd0, stall_o}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("alu_latency1", {31'd0, out_valid}, 32'd1);
    check("alu_stall_after", {31'd0, stall_o}, 32'd0);
  endtask

  task automatic do_store(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [2:0] f3, input int waits,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    issue(pc, addr, rs2, 1'b0, 1'b1, f3);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check("st_req", {31'd0, dm_req}, 32'd1);
      check("st_we", {31'd0, dm_we}, 32'd1);
      check("st_addr", dm_addr, {addr[31:2], 2'b00});
      check("st_wdata", dm_wdata, exp_wdata);
      check("st_wstrb", {28'd0, dm_wstrb}, {28'd0, exp_wstrb});
      check("st_stall", {31'd0, stall_o}, 32'd1);
      if (i == waits) begin
        dm_ready = 1'b1;
        sb.push_back('{pc: pc, data: 32'd0, exc: 1'b0});
      end
      tick();
    end
    dm_ready = 1'b0;
    check("st_done_valid", {31'd0, out_valid}, 32'd1);
    check("st_done_req", {31'd0, dm_req}, 32'd0);
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(pc, addr, 32'h0, 1'b1, 1'b0, f3);
    tick();
    in_valid = 1'b0;
    check("ld_req", {31'd0, dm_req}, 32'd1);
    check("ld_we", {31'd0, dm_we}, 32'd0);
    check("ld_wstrb", {28'd0, dm_wstrb}, 32'd0);
    check("ld_addr", dm_addr, {addr[31:2], 2'b00});
    // Read data presented with the accept must not be taken.
    dm_ready  = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hDEADBEEF;
    tick();
    dm_ready = 1'b0;
    dm_rdata = rdata;
    check("ld_resp_req", {31'd0, dm_req}, 32'd0);
    check("ld_resp_stall", {31'd0, stall_o}, 32'd1);
    sb.push_back('{pc: pc, data: exp, exc: 1'b0});
    tick();
    dm_rvalid = 1'b0;
    check("ld_done_valid", {31'd0, out_valid}, 32'd1);
    check("ld_done_stall", {31'd0, stall_o}, 32'd0);
  endtask

  task automatic do_exc(input logic [31:0] pc, input logic [31:0] addr, input logic ld,
                        input logic st, input logic [2:0] f3);
    issue(pc, addr, 32'h55AA55AA, ld, st, f3);
    sb.push_back('{pc: pc, data: 32'd0, exc: 1'b1});
    tick();
    in_valid = 1'b0;
    check("exc_no_req", {31'd0, dm_req}, 32'd0);
    check("exc_no_stall", {31'd0, stall_o}, 32'd0);
    check("exc_valid", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = '0; in_alu_out = '0; in_rs2_data = '0;
    in_load = 1'b0; in_store = 1'b0; in_funct3 = '0;
    dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_out_wb_data", out_wb_data, 32'd0);
    rst = 1'b0;
    tick();

    do_alu(32'h40, 32'h1234_5678);
    tick();
    check("alu_pulse_drop", {31'd0, out_valid}, 32'd0);
    check("alu_hold_data", out_wb_data, 32'h1234_5678);

    do_store(32'h44, 32'h1003, 32'hAABBCCDD, 3'b000, 2, 32'hDDDDDDDD, 4'b1000);
    do_store(32'h48, 32'h3002, 32'h1234ABCD, 3'b001, 0, 32'hABCDABCD, 4'b1100);
    do_store(32'h4C, 32'h3004, 32'hCAFEF00D, 3'b010, 1, 32'hCAFEF00D, 4'b1111);

    do_load(32'h50, 32'h2001, 3'b000, 32'h80FF7F01, 32'h0000007F);
    do_load(32'h54, 32'h2002, 3'b001, 32'h80FF7F01, 32'hFFFF80FF);
    do_load(32'h58, 32'h2003, 3'b100, 32'h80FF7F01, 32'h00000080);
    do_load(32'h5C, 32'h2000, 3'b010, 32'h80FF7F01, 32'h80FF7F01);
    do_load(32'h60, 32'h2000, 3'b101, 32'h80FF7F01, 32'h00007F01);

    do_exc(32'h64, 32'h1002, 1'b1, 1'b0, 3'b010);
    do_exc(32'h68, 32'h1000, 1'b1, 1'b0, 3'b011);
    do_exc(32'h6C, 32'h1000, 1'b1, 1'b1, 3'b010);
    do_exc(32'h70, 32'h1000, 1'b0, 1'b1, 3'b100);
    do_exc(32'h74, 32'h1001, 1'b0, 1'b1, 3'b001);

    // Memory never accepts: the request must be abandoned after 4 cycles.
    issue(32'h80, 32'h4000, 32'h0, 1'b1, 1'b0, 3'b010);
    sb.push_back('{pc: 32'h80, data: 32'd0, exc: 1'b1});
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_req_held", {31'd0, dm_req}, 32'd1);
      tick();
    end
    check("to_req_drop", {31'd0, dm_req}, 32'd0);
    check("to_stall_drop", {31'd0, stall_o}, 32'd0);
    check("to_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Asynchronous reset while a load request is pending.
    issue(32'h90, 32'h5000, 32'h0, 1'b1, 1'b0, 3'b010);
    tick();
    in_valid = 1'b0;
    check("rr_req_before", {31'd0, dm_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("rr_req", {31'd0, dm_req}, 32'd0);
    check("rr_stall", {31'd0, stall_o}, 32'd0);
    check("rr_valid", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_alu(32'hA0, 32'h0BAD_F00D);
    tick();
    tick();

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
